// File: rtl/mem_read_responder.sv
// mem_read_responder: pipelined word memory returning read data a fixed LATENCY cycles after each request
module mem_read_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 10,
    parameter int LATENCY = 4,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [CNT_W-1:0]  outstanding
);
    localparam int WORDS = 1 << DEPTH_W;

    logic [DATA_W-1:0] mem [WORDS];
    logic [LATENCY-1:0] vld;
    logic [DATA_W-1:0] dat [LATENCY];
    logic [ADDR_W-1:0] adr [LATENCY];
    logic rd_req;
    logic rd_done;

    assign rd_req  = enable && !wr;
    assign rd_done = vld[LATENCY-1];

    // storage write port; writes presented during reset are discarded
    always_ff @(posedge clk) begin
        if (!rst && enable && wr) mem[addr[DEPTH_W-1:0]] <= data_in;
    end

    // read pipeline: data is captured at issue so a later write cannot alter it
    always_ff @(posedge clk) begin
        vld[0] <= rst ? 1'b0 : rd_req;
        dat[0] <= mem[addr[DEPTH_W-1:0]];
        adr[0] <= addr;
        for (int i = 1; i < LATENCY; i++) begin
            vld[i] <= rst ? 1'b0 : vld[i-1];
            dat[i] <= dat[i-1];
            adr[i] <= adr[i-1];
        end
    end

    // response registers and in-flight read counter; data_out holds between returns
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid  <= 1'b0;
            data_out    <= '0;
            rd_addr_out <= '0;
            outstanding <= '0;
        end else begin
            data_valid  <= rd_done;
            data_out    <= rd_done ? dat[LATENCY-1] : data_out;
            rd_addr_out <= rd_done ? adr[LATENCY-1] : rd_addr_out;
            outstanding <= outstanding + CNT_W'(rd_req) - CNT_W'(rd_done);
        end
    end
endmodule
